// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared definitions for the boot-time ROM loader: FSM state
//                encodings, default frame sync byte and a state classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_loader_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_ST_IDLE    = 4'd0;
    localparam state_t c_ST_LEN_HI  = 4'd1;
    localparam state_t c_ST_LEN_LO  = 4'd2;
    localparam state_t c_ST_DATA_HI = 4'd3;
    localparam state_t c_ST_DATA_LO = 4'd4;
    localparam state_t c_ST_CSUM_HI = 4'd5;
    localparam state_t c_ST_CSUM_LO = 4'd6;
    localparam state_t c_ST_RUN     = 4'd7;
    localparam state_t c_ST_ERR     = 4'd8;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

    // A frame is "in progress" from the first length byte up to the last
    // checksum byte; these encodings are contiguous.
    function automatic logic is_busy_state(input state_t s);
        return (s >= c_ST_LEN_HI) && (s <= c_ST_CSUM_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : loader_timeout
//  Description : Inter-byte watchdog. Down-counter reloaded on every received
//                byte; 'expired' is high once TIMEOUT_CYCLES cycles have
//                elapsed since the last reload. TIMEOUT_CYCLES=0 disables it.
//  Ports       : clk, reset (async, active-high), reload (in), expired (out)
//  Revision    : 1.0  initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic expired
);

    localparam logic c_EN   = (TIMEOUT_CYCLES > 0);
    localparam int   c_CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loading N-1 makes the counter read zero during the N-th idle cycle, so
    // the owner acts on that cycle's edge unless a byte arrives in it.
    localparam int   c_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (reload) begin
            r_count <= c_CW'(c_LOAD);
        end else if (r_count != '0) begin
            r_count <= r_count - c_CW'(1);
        end
    end

    assign expired = c_EN && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Boot loader between the UART receiver and the Hack CPU.
//                Frame: SYNC, LEN_HI, LEN_LO, {W_HI,W_LO} x LEN, CSUM_HI,
//                CSUM_LO (big-endian). Words are written to instruction ROM
//                from address 0; the CPU is released only after a frame with
//                a matching 16-bit wrap-around checksum.
//  Ports       : clk, reset (async, active-high)
//                rx_data[7:0], rx_valid     - byte stream from UART
//                load_req                   - request a reload while running
//                rom_we, rom_addr, rom_wdata - ROM write port
//                cpu_reset, busy, error     - status / CPU hold
//  Revision    : 1.0  initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         ADDR_W         = 15,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = c_SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              load_req,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error
);

    // ROM capacity in words; LEN may equal but not exceed this.
    localparam logic [16:0] c_CAP = 17'(1) << ADDR_W;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [7:0]  r_hi;
    logic [16:0] r_count;
    logic [15:0] r_csum;

    logic [15:0] w_len;
    logic [15:0] w_word;
    logic        w_expired;
    logic        w_timeout;
    logic        w_sync_accept;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .reload  (rx_valid),
        .expired (w_expired)
    );

    assign w_len         = {r_len_hi, rx_data};
    assign w_word        = {r_hi, rx_data};
    // A byte in the expiry cycle wins, hence the !rx_valid term.
    assign w_timeout     = is_busy_state(r_state) && !rx_valid && w_expired;
    assign w_sync_accept = rx_valid && (rx_data == SYNC_BYTE) &&
                           ((r_state == c_ST_IDLE) || (r_state == c_ST_ERR));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_ERR: begin
                if (w_sync_accept) w_state_nxt = c_ST_LEN_HI;
            end
            c_ST_LEN_HI: begin
                if (rx_valid) w_state_nxt = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (rx_valid) begin
                    if ({1'b0, w_len} > c_CAP) w_state_nxt = c_ST_ERR;
                    else if (w_len == 16'd0)   w_state_nxt = c_ST_CSUM_HI;
                    else                       w_state_nxt = c_ST_DATA_HI;
                end
            end
            c_ST_DATA_HI: begin
                if (rx_valid) w_state_nxt = c_ST_DATA_LO;
            end
            c_ST_DATA_LO: begin
                if (rx_valid) begin
                    if ((r_count + 17'd1) == {1'b0, r_len}) w_state_nxt = c_ST_CSUM_HI;
                    else                                     w_state_nxt = c_ST_DATA_HI;
                end
            end
            c_ST_CSUM_HI: begin
                if (rx_valid) w_state_nxt = c_ST_CSUM_LO;
            end
            c_ST_CSUM_LO: begin
                if (rx_valid) w_state_nxt = (w_word == r_csum) ? c_ST_RUN : c_ST_ERR;
            end
            c_ST_RUN: begin
                if (load_req) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = c_ST_ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_hi      <= '0;
            r_count   <= '0;
            r_csum    <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            busy      <= is_busy_state(w_state_nxt);
            cpu_reset <= (w_state_nxt != c_ST_RUN);

            if (w_state_nxt == c_ST_ERR) error <= 1'b1;
            else if (w_sync_accept)      error <= 1'b0;

            // Address advances the cycle after each write strobe.
            rom_we <= 1'b0;
            if (rom_we) rom_addr <= rom_addr + ADDR_W'(1);

            if (rx_valid) begin
                case (r_state)
                    c_ST_IDLE, c_ST_ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            rom_addr <= '0;
                            r_count  <= '0;
                            r_csum   <= '0;
                        end
                    end
                    c_ST_LEN_HI:  r_len_hi <= rx_data;
                    c_ST_LEN_LO:  r_len    <= w_len;
                    c_ST_DATA_HI: r_hi     <= rx_data;
                    c_ST_DATA_LO: begin
                        rom_we    <= 1'b1;
                        rom_wdata <= w_word;
                        r_csum    <= r_csum + w_word;
                        r_count   <= r_count + 17'd1;
                    end
                    c_ST_CSUM_HI: r_hi     <= rx_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader (ADDR_W=4, timeout 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_loader;

    localparam int c_ADDR_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                load_req = 1'b0;
    logic                rom_we;
    logic [c_ADDR_W-1:0] rom_addr;
    logic [15:0]         rom_wdata;
    logic                cpu_reset;
    logic                busy;
    logic                error;

    int checks = 0;
    int failures = 0;

    rom_loader #(
        .ADDR_W         (c_ADDR_W),
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .load_req  (load_req),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    // ROM write log, sampled at the rising edge (pre-update values).
    int          n_wr = 0;
    logic [15:0] wr_data [32];
    logic [3:0]  wr_addr [32];
    always @(posedge clk) begin
        if (rom_we && n_wr < 32) begin
            wr_addr[n_wr] = rom_addr;
            wr_data[n_wr] = rom_wdata;
            n_wr = n_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte is presented for one cycle; returns at the falling edge after capture.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [95:0] bytes);
        for (int i = 0; i < n; i++) send_byte(bytes[95-8*i -: 8]);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [95:0] bytes;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        err;
        logic        cpur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"good2",   9, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,8'h10,8'hEC,8'h12,8'h00,8'h00,8'h00}, 2, 16'h0002, 16'hEC10, 1'b0, 1'b0};
        vecs[1] = '{"badcsum", 9, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,8'h10,8'hEC,8'h13,8'h00,8'h00,8'h00}, 2, 16'h0002, 16'hEC10, 1'b1, 1'b1};
        vecs[2] = '{"recover", 9, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,8'h10,8'hEC,8'h12,8'h00,8'h00,8'h00}, 2, 16'h0002, 16'hEC10, 1'b0, 1'b0};
        vecs[3] = '{"len0",    5, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{"lenbig",  3, {8'hA5,8'h00,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{"csumwrap",9, {8'hA5,8'h00,8'h02,8'hFF,8'hFF,8'h00,8'h02,8'h00,8'h01,8'h00,8'h00,8'h00}, 2, 16'hFFFF, 16'h0002, 1'b0, 1'b0};
        vecs[6] = '{"syncdata",7, {8'hA5,8'h00,8'h01,8'hA5,8'hA5,8'hA5,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{"junkpre", 8, {8'h12,8'hA5,8'h00,8'h01,8'h00,8'h07,8'h00,8'h07,8'h00,8'h00,8'h00,8'h00}, 1, 16'h0007, 16'h0000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_rom_we",    32'(rom_we),    32'd0);
        chk("rst_rom_addr",  32'(rom_addr),  32'd0);
        chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_error",     32'(error),     32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            pulse_load_req();
            n_wr = 0;
            send_frame(vecs[v].n, vecs[v].bytes);
            repeat (2) @(negedge clk);
            chk({vecs[v].name, "_nwr"}, 32'(n_wr), 32'(vecs[v].nw));
            for (int i = 0; i < vecs[v].nw && i < n_wr && i < 2; i++) begin
                chk({vecs[v].name, "_addr"}, 32'(wr_addr[i]), 32'(i));
                chk({vecs[v].name, "_data"}, 32'(wr_data[i]), 32'(i == 0 ? vecs[v].w0 : vecs[v].w1));
            end
            chk({vecs[v].name, "_error"},     32'(error),     32'(vecs[v].err));
            chk({vecs[v].name, "_cpu_reset"}, 32'(cpu_reset), 32'(vecs[v].cpur));
            chk({vecs[v].name, "_busy"},      32'(busy),      32'd0);
        end

        // Release timing: cpu_reset falls exactly one cycle after the last byte
        pulse_load_req();
        send_frame(8, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,8'h10,8'hEC,8'h00,8'h00,8'h00,8'h00});
        chk("rel_busy_before", 32'(busy),      32'd1);
        chk("rel_cpu_before",  32'(cpu_reset), 32'd1);
        chk("rel_addr_after2", 32'(rom_addr),  32'd2);
        send_byte(8'h12);
        chk("rel_cpu_after",   32'(cpu_reset), 32'd0);
        chk("rel_busy_after",  32'(busy),      32'd0);

        // load_req in RUN: re-hold CPU next cycle and stay held
        send_byte(8'hA5);
        chk("run_ignores_bytes", 32'(cpu_reset), 32'd0);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("loadreq_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (5) @(negedge clk);
        chk("loadreq_cpu_hold",  32'(cpu_reset), 32'd1);

        // load_req during DATA_HI is ignored
        n_wr = 0;
        send_frame(3, {8'hA5,8'h00,8'h01,72'h0});
        pulse_load_req();
        send_frame(4, {8'h12,8'h34,8'h12,8'h34,64'h0});
        repeat (2) @(negedge clk);
        chk("ldhi_nwr",       32'(n_wr),      32'd1);
        chk("ldhi_cpu_reset", 32'(cpu_reset), 32'd0);

        // Timeout: 16 idle cycles after first data byte -> ERR
        pulse_load_req();
        send_frame(4, {8'hA5,8'h00,8'h01,8'h00,64'h0});
        repeat (15) @(negedge clk);
        chk("to15_error", 32'(error), 32'd0);
        chk("to15_busy",  32'(busy),  32'd1);
        @(negedge clk);
        chk("to16_error",     32'(error),     32'd1);
        chk("to16_busy",      32'(busy),      32'd0);
        chk("to16_cpu_reset", 32'(cpu_reset), 32'd1);

        // Stall of 15 idle cycles: frame still completes
        n_wr = 0;
        send_frame(4, {8'hA5,8'h00,8'h01,8'h00,64'h0});
        repeat (14) @(negedge clk);
        send_frame(3, {8'h05,8'h00,8'h05,72'h0});
        repeat (2) @(negedge clk);
        chk("st15_nwr",       32'(n_wr),      32'd1);
        chk("st15_error",     32'(error),     32'd0);
        chk("st15_cpu_reset", 32'(cpu_reset), 32'd0);

        // Async reset during DATA_LO of word 1
        pulse_load_req();
        send_frame(6, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,48'h0});
        chk("mid_addr_before", 32'(rom_addr), 32'd1);
        chk("mid_busy_before", 32'(busy),     32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_addr",  32'(rom_addr),  32'd0);
        chk("mid_rst_wdata", 32'(rom_wdata), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_cpu",   32'(cpu_reset), 32'd1);
        chk("mid_rst_we",    32'(rom_we),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_wr = 0;
        send_frame(9, {8'hA5,8'h00,8'h02,8'h00,8'h02,8'hEC,8'h10,8'hEC,8'h12,24'h0});
        repeat (2) @(negedge clk);
        chk("post_rst_nwr", 32'(n_wr),      32'd2);
        chk("post_rst_cpu", 32'(cpu_reset), 32'd0);
        chk("post_rst_err", 32'(error),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
